multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage of the 5-stage pipeline, directly downstream of the instruction decoder. It consumes the decoder's multiply and divide strobes for R-type ALU ops 6 and 7 together with the register-file operands. It produces a fixed-latency result, an exception flag and the destination tag for writeback, and holds `busy` so the hazard logic can stall fetch, decode and execute.

---
 rtl/multdiv_defs.sv | 21 ++
 rtl/abs_negate_32bit.sv | 11 +
 rtl/multdiv_unit.sv | 160 ++++++++++++++++
 tb/tb_multdiv_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_defs.sv
// Shared definitions for the iterative multiply/divide unit and the decoder.
// Covers state and op encodings, latency, ALU opcodes and the INT_MIN constant.
package multdiv_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } md_op_e;

   localparam int          MD_LATENCY  = 33;
   localparam logic [2:0]  ALU_OP_MULT = 3'd6;
   localparam logic [2:0]  ALU_OP_DIV  = 3'd7;
   localparam logic [31:0] INT_MIN     = 32'h8000_0000;

endpackage

// File: rtl/abs_negate_32bit.sv
// Two's-complement conditional negate; used for operand magnitudes and sign fixup.
// INT_MIN maps onto itself, which reads correctly as the unsigned magnitude 2^31.
module abs_negate_32bit (
   input  logic [31:0] in,
   input  logic        negate,
   output logic [31:0] out
);

   assign out = negate ? (~in + 32'd1) : in;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) unit.
// One bit per RUN cycle; result_ready pulses 33 cycles after the accepting edge.
module multdiv_unit
   import multdiv_defs::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ITERS      = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_mult,
   input  logic                  start_div,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [4:0]            dest_in,
   output logic                  busy,
   output logic                  result_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  exception,
   output logic [4:0]            dest_out
);

   localparam int CW = $clog2(ITERS);

   md_state_e             state_q, state_d;
   md_op_e                op_q, op_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  sign_a_q, sign_a_d;
   logic                  sign_b_q, sign_b_d;
   logic [DATA_WIDTH-1:0] mag_a_q, mag_a_d;
   logic [DATA_WIDTH-1:0] mag_b_q, mag_b_d;
   logic [63:0]           acc_q, acc_d;
   logic [4:0]            dest_q, dest_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  exc_q, exc_d;
   logic [4:0]            dest_out_q, dest_out_d;

   logic [31:0] abs_a, abs_b, lo_fix, hi_fix;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [63:0] mul_step, div_step, prod;
   logic        neg, div_zero, fix_exc;
   logic [31:0] fix_result;

   abs_negate_32bit u_abs_a (.in(operand_a), .negate(operand_a[31]), .out(abs_a));
   abs_negate_32bit u_abs_b (.in(operand_b), .negate(operand_b[31]), .out(abs_b));
   // Product low word and quotient both live in acc_q[31:0], so one fixup serves both.
   abs_negate_32bit u_fix   (.in(acc_q[31:0]), .negate(neg), .out(lo_fix));

   always_comb begin
      // Multiply: accumulate into the upper half, shift multiplier out of the lower half.
      mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_a_q : 32'd0)};
      mul_step = {mul_sum, acc_q[31:1]};

      // Divide: acc_q holds {remainder, dividend/quotient}; the remainder never exceeds 32 bits.
      div_shift = {acc_q[63:32], acc_q[31]};
      div_diff  = div_shift - {1'b0, mag_b_q};
      if (!div_diff[32]) begin
         div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
         div_step = {div_shift[31:0], acc_q[30:0], 1'b0};
      end
   end

   always_comb begin
      neg      = sign_a_q ^ sign_b_q;
      div_zero = (mag_b_q == 32'd0);
      // High word of the 64-bit negate takes the carry out of the low word.
      hi_fix   = neg ? (~acc_q[63:32] + {31'd0, (acc_q[31:0] == 32'd0)}) : acc_q[63:32];
      prod     = {hi_fix, lo_fix};
      if (op_q == OP_MULT) begin
         fix_result = lo_fix;
         fix_exc    = !((&prod[63:31]) || !(|prod[63:31]));
      end else begin
         fix_result = div_zero ? 32'd0 : lo_fix;
         fix_exc    = div_zero || (!neg && acc_q[31]);
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      mag_a_d    = mag_a_q;
      mag_b_d    = mag_b_q;
      acc_d      = acc_q;
      dest_d     = dest_q;
      result_d   = result_q;
      exc_d      = exc_q;
      dest_out_d = dest_out_q;

      case (state_q)
         ST_RUN: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = (op_q == OP_MULT) ? mul_step : div_step;
            if (cnt_q == CW'(ITERS - 1)) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            if (state_q == ST_DONE) begin
               result_d   = fix_result;
               exc_d      = fix_exc;
               dest_out_d = dest_q;
            end
            state_d = ST_IDLE;
            if (start_mult || start_div) begin
               state_d  = ST_RUN;
               op_d     = start_mult ? OP_MULT : OP_DIV;
               cnt_d    = '0;
               sign_a_d = operand_a[31];
               sign_b_d = operand_b[31];
               mag_a_d  = abs_a;
               mag_b_d  = abs_b;
               dest_d   = dest_in;
               acc_d    = {32'd0, (start_mult ? abs_b : abs_a)};
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_MULT;
         cnt_q      <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         acc_q      <= '0;
         dest_q     <= '0;
         result_q   <= '0;
         exc_q      <= 1'b0;
         dest_out_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         mag_a_q    <= mag_a_d;
         mag_b_q    <= mag_b_d;
         acc_q      <= acc_d;
         dest_q     <= dest_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
         dest_out_q <= dest_out_d;
      end
   end

   // In DONE the fresh result is shown directly; afterwards the held copy is.
   assign busy         = (state_q == ST_RUN);
   assign result_ready = (state_q == ST_DONE);
   assign result       = result_ready ? fix_result : result_q;
   assign exception    = result_ready ? fix_exc    : exc_q;
   assign dest_out     = result_ready ? dest_q     : dest_out_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: hand-computed products/quotients, timing and conflicts.
module tb_multdiv_unit;

   logic        clock;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [4:0]  dest_in;
   logic        busy;
   logic        result_ready;
   logic [31:0] result;
   logic        exception;
   logic [4:0]  dest_out;

   int checks = 0;
   int errors = 0;

   multdiv_unit #(.DATA_WIDTH(32), .ITERS(32)) dut (
      .clock(clock), .reset(reset),
      .start_mult(start_mult), .start_div(start_div),
      .operand_a(operand_a), .operand_b(operand_b), .dest_in(dest_in),
      .busy(busy), .result_ready(result_ready), .result(result),
      .exception(exception), .dest_out(dest_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge (cycle 0).
   task automatic run_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                         input logic [31:0] exp_res, input logic exp_exc, input int inject);
      int bad;
      bad = 0;
      start_mult = m;
      start_div  = d;
      operand_a  = a;
      operand_b  = b;
      dest_in    = dst;
      @(posedge clock);
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         if (k == 1) begin
            start_mult = 1'b0;
            start_div  = 1'b0;
            dest_in    = 5'd0;
         end
         if (k == inject) begin
            start_div = 1'b1;
            operand_a = 32'd1000;
            operand_b = 32'd10;
            dest_in   = 5'd31;
         end else if (k == inject + 1) begin
            start_div = 1'b0;
            dest_in   = 5'd0;
         end
         if (k < 33) begin
            if (busy !== 1'b1 || result_ready !== 1'b0) bad++;
         end else begin
            chk({tag, "_busy_window"}, 32'(bad), 32'd0);
            chk({tag, "_ready"}, {31'd0, result_ready}, 32'd1);
            chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
            chk({tag, "_result"}, result, exp_res);
            chk({tag, "_exception"}, {31'd0, exception}, {31'd0, exp_exc});
            chk({tag, "_dest"}, {27'd0, dest_out}, {27'd0, dst});
         end
      end
   endtask

   task automatic count_ready(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clock);
         if (result_ready === 1'b1) n++;
      end
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      operand_a  = '0;
      operand_b  = '0;
      dest_in    = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, result_ready}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_exc", {31'd0, exception}, 32'd0);
      chk("rst_dest", {27'd0, dest_out}, 32'd0);

      // Starts while reset is held are dropped.
      start_mult = 1'b1;
      operand_a  = 32'd3;
      operand_b  = 32'd3;
      @(posedge clock);
      @(negedge clock);
      start_mult = 1'b0;
      chk("rst_held_start", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op("mul_7xm6", 1, 0, 32'd7, 32'hFFFF_FFFA, 5'd1, 32'hFFFF_FFD6, 0, 0);
      repeat (2) @(negedge clock);
      chk("hold_result", result, 32'hFFFF_FFD6);
      chk("hold_dest", {27'd0, dest_out}, 32'd1);
      chk("hold_ready", {31'd0, result_ready}, 32'd0);

      run_op("mul_ovf16", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0000, 1, 0);
      repeat (2) @(negedge clock);
      run_op("mul_min_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1, 0);
      repeat (2) @(negedge clock);
      run_op("mul_max_max", 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd4, 32'h0000_0001, 1, 0);
      repeat (2) @(negedge clock);
      run_op("mul_min_1", 1, 0, 32'h8000_0000, 32'd1, 5'd5, 32'h8000_0000, 0, 0);
      repeat (2) @(negedge clock);

      run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 0, 0);
      repeat (2) @(negedge clock);
      run_op("div_100_0", 0, 1, 32'd100, 32'd0, 5'd7, 32'h0000_0000, 1, 0);
      repeat (2) @(negedge clock);
      run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, 0);
      repeat (2) @(negedge clock);
      run_op("div_m8_m3", 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd9, 32'd2, 0, 0);
      repeat (2) @(negedge clock);
      run_op("div_min_1", 0, 1, 32'h8000_0000, 32'd1, 5'd10, 32'h8000_0000, 0, 0);
      repeat (2) @(negedge clock);

      run_op("both_9_3", 1, 1, 32'd9, 32'd3, 5'd11, 32'd27, 0, 0);
      repeat (2) @(negedge clock);
      run_op("run_ignore", 1, 0, 32'd6, 32'd7, 5'd12, 32'd42, 0, 10);
      count_ready(40, n);
      chk("run_ignore_extra_ready", 32'(n), 32'd0);
      chk("run_ignore_held", result, 32'd42);

      // Second start is issued in the DONE cycle of the first.
      run_op("b2b_5x5", 1, 0, 32'd5, 32'd5, 5'd13, 32'd25, 0, 0);
      run_op("b2b_12d4", 0, 1, 32'd12, 32'd4, 5'd14, 32'd3, 0, 0);
      repeat (2) @(negedge clock);

      // Abort mid-RUN with reset, then restart two cycles later.
      start_mult = 1'b1;
      operand_a  = 32'd7;
      operand_b  = 32'd3;
      dest_in    = 5'd15;
      @(posedge clock);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clock);
         start_mult = 1'b0;
      end
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, result_ready}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_exc", {31'd0, exception}, 32'd0);
      chk("abort_dest", {27'd0, dest_out}, 32'd0);
      @(negedge clock);
      chk("abort_idle_ready", {31'd0, result_ready}, 32'd0);
      run_op("after_abort", 0, 1, 32'hFFFF_FF9C, 32'd7, 5'd16, 32'hFFFF_FFF2, 0, 0);
      count_ready(5, n);
      chk("after_abort_extra_ready", 32'(n), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
